// File: rtl/instruction_fetch_unit.sv
// IF stage: program counter, instruction memory, debug program-load port and halt detection.
// Fetched word and its PC+4 are registered towards decode.
module instruction_fetch_unit #(
    parameter int unsigned                NB_INSTRUCTIONS = 32,
    parameter int unsigned                NB_ADDRESS      = 32,
    parameter int unsigned                N_INSTR_MEM     = 256,
    parameter int unsigned                NB_MEM_ADDR     = 8,
    parameter logic [NB_INSTRUCTIONS-1:0] HALT_WORD       = 32'hFFFFFFFF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       if_stall_i,
    input  logic                       if_branch_i,
    input  logic [NB_ADDRESS-1:0]      if_branch_addr_i,
    input  logic                       enable_i,
    input  logic                       step_i,
    input  logic                       load_start_i,
    input  logic                       load_valid_i,
    input  logic [NB_INSTRUCTIONS-1:0] load_data_i,
    input  logic                       load_done_i,
    output logic [NB_INSTRUCTIONS-1:0] instruction_o,
    output logic [NB_ADDRESS-1:0]      pc_o,
    output logic                       load_ready_o,
    output logic [NB_MEM_ADDR:0]       load_ptr_o,
    output logic                       halt_o
);

    localparam int unsigned             PtrW     = NB_MEM_ADDR + 1;
    localparam logic [PtrW-1:0]         MemDepth = PtrW'(N_INSTR_MEM);
    localparam logic [NB_ADDRESS-1:0]   PcStep   = NB_ADDRESS'(4);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalt} state_e;

    state_e                     state_q, state_d;
    logic [NB_ADDRESS-1:0]      pc_q, pc_d;
    logic [PtrW-1:0]            ptr_q, ptr_d;
    logic [NB_INSTRUCTIONS-1:0] instr_q, instr_d;
    logic [NB_ADDRESS-1:0]      opc_q, opc_d;
    logic                       halt_q, halt_d;
    logic                       ready_q, ready_d;

    logic [NB_INSTRUCTIONS-1:0] mem_q [N_INSTR_MEM];
    logic                       mem_we;
    logic [NB_INSTRUCTIONS-1:0] fetch_word;
    logic [NB_ADDRESS-1:0]      pc_plus4;
    logic                       advance;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        halt_d     = halt_q;
        mem_we     = 1'b0;
        fetch_word = mem_q[pc_q[NB_MEM_ADDR+1:2]];
        pc_plus4   = pc_q + PcStep;
        advance    = ~if_stall_i & (enable_i | step_i);

        case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                end else if (enable_i || step_i) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                // Pointer saturates at the memory depth; extra words are dropped.
                if (load_valid_i && (ptr_q < MemDepth)) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end
                if (load_start_i) begin
                    ptr_d = '0;
                end
                if (load_done_i) begin
                    pc_d    = '0;
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (advance) begin
                    if (fetch_word == HALT_WORD) begin
                        instr_d = '0;
                        halt_d  = 1'b1;
                        state_d = StHalt;
                    end else begin
                        instr_d = fetch_word;
                        opc_d   = pc_plus4;
                        // The delay slot is fetched on this edge while the target lands in pc.
                        pc_d    = if_branch_i ? if_branch_addr_i : pc_plus4;
                    end
                end
            end
            StHalt: begin
                instr_d = '0;
                halt_d  = 1'b1;
                if (load_start_i) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    halt_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StLoad) && (ptr_d < MemDepth);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ptr_q   <= '0;
            instr_q <= '0;
            opc_q   <= '0;
            halt_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            halt_q  <= halt_d;
            ready_q <= ready_d;
        end
    end

    // Program memory keeps its contents across reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[ptr_q[NB_MEM_ADDR-1:0]] <= load_data_i;
        end
    end

    assign instruction_o = instr_q;
    assign pc_o          = opc_q;
    assign load_ready_o  = ready_q;
    assign load_ptr_o    = ptr_q;
    assign halt_o        = halt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, enable = 1'b0, step = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0;
    logic [31:0] branch_addr = '0, load_data = '0;
    logic [31:0] instr, pc;
    logic        ready, halt;
    logic [8:0]  ptr;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .if_stall_i       (stall),
        .if_branch_i      (branch),
        .if_branch_addr_i (branch_addr),
        .enable_i         (enable),
        .step_i           (step),
        .load_start_i     (load_start),
        .load_valid_i     (load_valid),
        .load_data_i      (load_data),
        .load_done_i      (load_done),
        .instruction_o    (instr),
        .pc_o             (pc),
        .load_ready_o     (ready),
        .load_ptr_o       (ptr),
        .halt_o           (halt)
    );

    typedef struct {
        string       name;
        int          due;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        halt;
        logic        ready;
        logic [8:0]  ptr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] e_instr = '0, e_pc = '0;
    logic        e_halt = 1'b0, e_ready = 1'b0;
    logic [8:0]  e_ptr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] prog(input int i);
        if (i == 5) return 32'hFFFF_FFFF;
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name);
        exp_t e;
        e.name  = name;
        e.due   = cyc;
        e.instr = e_instr;
        e.pc    = e_pc;
        e.halt  = e_halt;
        e.ready = e_ready;
        e.ptr   = e_ptr;
        sb.push_back(e);
    endtask

    task automatic exp_fetch(input string name, input logic [31:0] w, input logic [31:0] p);
        e_instr = w;
        e_pc    = p;
        push_exp(name);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.due == cyc && instr === mon_e.instr && pc === mon_e.pc &&
                halt === mon_e.halt && ready === mon_e.ready && ptr === mon_e.ptr) begin
                n_pass++;
            end else begin
                $display("FAIL %s (cycle %0d): got instr=%h pc=%h halt=%b ready=%b ptr=%0d, want instr=%h pc=%h halt=%b ready=%b ptr=%0d",
                         mon_e.name, cyc, instr, pc, halt, ready, ptr,
                         mon_e.instr, mon_e.pc, mon_e.halt, mon_e.ready, mon_e.ptr);
            end
        end
    end

    initial begin
        tick();
        tick();
        push_exp("reset");
        rst_n = 1'b1;

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        e_ready = 1'b1;
        e_ptr = 9'd0;
        push_exp("load_start");

        for (int i = 0; i < 258; i++) begin
            load_valid = 1'b1;
            load_data  = (i < 256) ? prog(i) : 32'hDEAD_BEEF;
            tick();
            if (i < 256) e_ptr = 9'(i + 1);
            e_ready = (i + 1 < 256);
            if (i == 0 || i == 254 || i == 255 || i == 257) push_exp("load_ptr");
        end
        load_valid = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        e_ready = 1'b0;
        push_exp("load_done");

        enable = 1'b1;
        tick();
        push_exp("run_entry_no_fetch");
        tick();
        exp_fetch("fetch0_no_wrap", prog(0), 32'd4);
        tick();
        exp_fetch("fetch1", prog(1), 32'd8);
        tick();
        exp_fetch("fetch2", prog(2), 32'd12);

        branch = 1'b1;
        branch_addr = 32'h40;
        tick();
        branch = 1'b0;
        exp_fetch("delay_slot", prog(3), 32'd16);
        tick();
        exp_fetch("branch_target", prog(16), 32'h44);

        stall = 1'b1;
        branch = 1'b1;
        branch_addr = 32'h100;
        tick();
        push_exp("stall1");
        tick();
        push_exp("stall2");
        stall = 1'b0;
        branch = 1'b0;
        tick();
        exp_fetch("stall_resume", prog(17), 32'h48);

        enable = 1'b0;
        tick();
        push_exp("paused");
        step = 1'b1;
        tick();
        step = 1'b0;
        exp_fetch("step1", prog(18), 32'h4C);
        tick();
        push_exp("step_gap");
        step = 1'b1;
        tick();
        step = 1'b0;
        exp_fetch("step2", prog(19), 32'h50);

        enable = 1'b1;
        branch = 1'b1;
        branch_addr = 32'h10;
        tick();
        branch = 1'b0;
        exp_fetch("slot_before_halt", prog(20), 32'h54);
        tick();
        exp_fetch("fetch4", prog(4), 32'd20);
        tick();
        e_halt = 1'b1;
        exp_fetch("halt", 32'h0, 32'd20);
        step = 1'b1;
        tick();
        step = 1'b0;
        push_exp("halt_hold");

        enable = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        e_halt = 1'b0;
        e_ready = 1'b1;
        e_ptr = 9'd0;
        push_exp("halt_exit_load");
        load_valid = 1'b1;
        load_data = prog(0);
        tick();
        e_ptr = 9'd1;
        push_exp("reload0");
        load_data = 32'hB000_0001;
        load_done = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done = 1'b0;
        e_ptr = 9'd2;
        e_ready = 1'b0;
        push_exp("done_with_write");

        enable = 1'b1;
        tick();
        push_exp("run_entry2");
        tick();
        exp_fetch("refetch0", prog(0), 32'd4);
        tick();
        exp_fetch("write_on_done", 32'hB000_0001, 32'd8);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        e_instr = '0;
        e_pc = '0;
        e_halt = 1'b0;
        e_ready = 1'b0;
        e_ptr = '0;
        push_exp("reset_midrun");
        tick();
        push_exp("post_reset_idle");
        tick();
        exp_fetch("post_reset_fetch", prog(0), 32'd4);
        enable = 1'b0;

        @(negedge clk);
        #1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
